// File: rtl/axil_mem_slave_if.sv
// AXI-Lite bus bundle for axil_mem_slave: write address/data/response and
// read address/data channels, with slave and master views.
interface axil_mem_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mem_slave.sv
// AXI-Lite slave backed by a DEPTH-word memory. The write path latches AW and
// W independently and commits once both are held; the read path answers with
// one cycle of latency. Out-of-range word indices return SLVERR.
module axil_mem_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic            s0_axi_aclk,
    input  logic            s0_axi_aresetn,
    axil_mem_slave_if.slave s0_axi
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // readies stay low during reset and rise on the first edge after release
    logic ready_en;

    w_state_t            w_state, w_state_nxt;
    logic                aw_held, w_held;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [1:0]          bresp_q;
    logic                aw_fire, w_fire, w_commit;
    logic [IDX_W-1:0]    cm_idx;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_W-1:0]   cm_strb;
    logic                cm_in_range;

    r_state_t            r_state, r_state_nxt;
    logic                ar_fire;
    logic [IDX_W-1:0]    ar_idx;
    logic                ar_in_range;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]          rresp_q;

    assign s0_axi.awready = ready_en && (w_state == W_IDLE) && !aw_held;
    assign s0_axi.wready  = ready_en && (w_state == W_IDLE) && !w_held;
    assign s0_axi.bvalid  = (w_state == W_RESP);
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = ready_en && (r_state == R_IDLE);
    assign s0_axi.rvalid  = (r_state == R_DATA);
    assign s0_axi.rdata   = rdata_q;
    assign s0_axi.rresp   = rresp_q;

    assign ar_idx      = s0_axi.araddr[ADDR_WIDTH-1:LSB];
    assign ar_in_range = {1'b0, ar_idx} < DEPTH_LIM;

    // Ready enable: set on every clocked edge out of reset.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) ready_en <= 1'b0;
        else                 ready_en <= 1'b1;
    end

    // Write FSM next state; commit address/data come from this cycle's bus
    // values when the matching channel has not been captured yet.
    always_comb begin
        w_state_nxt = w_state;
        w_commit    = 1'b0;
        aw_fire     = s0_axi.awvalid && s0_axi.awready;
        w_fire      = s0_axi.wvalid && s0_axi.wready;
        cm_idx      = aw_held ? aw_idx_q : s0_axi.awaddr[ADDR_WIDTH-1:LSB];
        cm_data     = w_held ? w_data_q : s0_axi.wdata;
        cm_strb     = w_held ? w_strb_q : s0_axi.wstrb;
        cm_in_range = {1'b0, cm_idx} < DEPTH_LIM;
        case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s0_axi.bready) w_state_nxt = W_IDLE;
            end
        endcase
    end

    // Write FSM state, channel captures and registered response.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (w_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s0_axi.awaddr[ADDR_WIDTH-1:LSB];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s0_axi.wdata;
                    w_strb_q <= s0_axi.wstrb;
                end
            end
        end
    end

    // Byte-masked memory write; storage is intentionally not reset.
    always_ff @(posedge s0_axi_aclk) begin
        if (w_commit && cm_in_range) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (cm_strb[b]) mem[cm_idx[MEM_AW-1:0]][8*b +: 8] <= cm_data[8*b +: 8];
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_nxt = r_state;
        ar_fire     = s0_axi.arvalid && s0_axi.arready;
        case (r_state)
            R_IDLE: if (ar_fire) r_state_nxt = R_DATA;
            R_DATA: if (s0_axi.rready) r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and read data register; sampling mem here on the same
    // edge as a write commit yields the pre-write word.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (ar_fire) begin
                if (ar_in_range) begin
                    rdata_q <= mem[ar_idx[MEM_AW-1:0]];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end
endmodule

// File: tb/tb_axil_mem_slave.sv
// Self-checking bench for axil_mem_slave: a word-level memory model produces
// expected responses which are queued at stimulus time and popped on output.
module tb_axil_mem_slave;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axil_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axil_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (rst_n),
        .s0_axi         (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] model [DEPTH];
    logic [1:0]    bq [$];
    rexp_t         rq [$];

    function automatic void exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [DW/8-1:0] s, input bit push);
        int unsigned idx = 32'(a[AW-1:2]);
        if (idx < DEPTH) begin
            for (int b = 0; b < DW/8; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            if (push) bq.push_back(2'b00);
        end else if (push) begin
            bq.push_back(2'b10);
        end
    endfunction

    function automatic void exp_read(input logic [AW-1:0] a);
        int unsigned idx = 32'(a[AW-1:2]);
        rexp_t e;
        if (idx < DEPTH) begin e.data = model[idx]; e.resp = 2'b00; end
        else             begin e.data = '0;         e.resp = 2'b10; end
        rq.push_back(e);
    endfunction

    // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
    // lat = cycles from commit edge to visible bvalid, -1 on timeout.
    task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW/8-1:0] strb, input int w_lead,
                               output int lat, output logic [1:0] resp);
        int aw_at, w_at, k;
        bit aw_done, w_done, aw_hs, w_hs;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; k = 0; lat = -1; resp = 2'bxx;
        @(posedge clk); #1;
        while (!(aw_done && w_done) && k < 40) begin
            if (k == aw_at) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
            if (k == w_at) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0; end
            k++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) return;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.bvalid) begin lat = c; resp = bus.bresp; break; end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            bus.bready = 1'b1;
            @(posedge clk); #1;
            bus.bready = 1'b0;
        end
    endtask

    task automatic drive_read(input logic [AW-1:0] addr, output int lat,
                              output logic [DW-1:0] data, output logic [1:0] resp);
        bit hs;
        hs = 0; lat = -1; data = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (hs) break;
        end
        bus.arvalid = 1'b0;
        if (!hs) return;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rvalid) begin lat = c; data = bus.rdata; resp = bus.rresp; break; end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            bus.rready = 1'b1;
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
    endtask

    task automatic test_reset;
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        compared++;
        if ({bus.bresp, bus.rresp} !== 4'b0 || bus.rdata !== '0) begin
            mismatched++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h required 00/00/0",
                     bus.bresp, bus.rresp, bus.rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            mismatched++;
            $display("FAIL reset_release: got %b required 11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
    endtask

    task automatic test_fill_readback;
        int lat;
        logic [1:0] resp, eb;
        logic [DW-1:0] data;
        rexp_t er;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'(i * 4);
            d = $urandom;
            exp_write(a, d, '1, 1'b1);
            drive_write(a, d, '1, (i % 3) - 1, lat, resp);
            eb = bq.pop_front();
            compared++;
            if (lat !== 0 || resp !== eb) begin
                mismatched++;
                $display("FAIL fill_wr[%0d]: lat=%0d bresp=%b required lat=0 bresp=%b", i, lat, resp, eb);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            exp_read(AW'(i * 4));
            drive_read(AW'(i * 4), lat, data, resp);
            er = rq.pop_front();
            compared++;
            if (lat !== 0 || data !== er.data || resp !== er.resp) begin
                mismatched++;
                $display("FAIL fill_rd[%0d]: lat=%0d rdata=%h rresp=%b required lat=0 rdata=%h rresp=%b",
                         i, lat, data, resp, er.data, er.resp);
            end
        end
    endtask

    // Table-driven single writes followed by read-back of the same address.
    task automatic test_write_variants;
        logic [AW-1:0]   ta [6] = '{8'h04, 8'h08, 8'h08, 8'h0C, 8'h7D, 8'h80};
        logic [DW-1:0]   td [6] = '{32'hDEADBEEF, 32'hAAAAAAAA, 32'h11223344, 32'hFFFFFFFF, 32'h0BADCAFE, 32'h12345678};
        logic [DW/8-1:0] ts [6] = '{4'hF, 4'hF, 4'h5, 4'h0, 4'hF, 4'hF};
        int              tl [6] = '{0, 0, 3, -2, 1, 0};
        int lat;
        logic [1:0] resp, eb;
        logic [DW-1:0] data;
        rexp_t er;
        for (int i = 0; i < 6; i++) begin
            exp_write(ta[i], td[i], ts[i], 1'b1);
            drive_write(ta[i], td[i], ts[i], tl[i], lat, resp);
            eb = bq.pop_front();
            compared++;
            if (lat !== 0 || resp !== eb) begin
                mismatched++;
                $display("FAIL wr_var[%0d]: lat=%0d bresp=%b required lat=0 bresp=%b", i, lat, resp, eb);
            end
            exp_read(ta[i]);
            drive_read(ta[i], lat, data, resp);
            er = rq.pop_front();
            compared++;
            if (lat !== 0 || data !== er.data || resp !== er.resp) begin
                mismatched++;
                $display("FAIL rd_var[%0d]: lat=%0d rdata=%h rresp=%b required lat=0 rdata=%h rresp=%b",
                         i, lat, data, resp, er.data, er.resp);
            end
        end
        // word 0 must be untouched by the out-of-range write to 0x80
        exp_read(8'h00);
        drive_read(8'h00, lat, data, resp);
        er = rq.pop_front();
        compared++;
        if (data !== er.data || resp !== er.resp) begin
            mismatched++;
            $display("FAIL oor_alias: rdata=%h rresp=%b required rdata=%h rresp=%b", data, resp, er.data, er.resp);
        end
        exp_read(8'hFC);
        drive_read(8'hFC, lat, data, resp);
        er = rq.pop_front();
        compared++;
        if (data !== er.data || resp !== er.resp) begin
            mismatched++;
            $display("FAIL oor_top: rdata=%h rresp=%b required rdata=%h rresp=%b", data, resp, er.data, er.resp);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] eb;
        rexp_t er;
        exp_write(8'h14, 32'hCAFEF00D, 4'hF, 1'b1);
        exp_read(8'h18);
        @(posedge clk); #1;
        bus.awaddr = 8'h14; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 8'h18; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        eb = bq.pop_front();
        er = rq.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            compared++;
            if ({bus.bvalid, bus.rvalid} !== 2'b11 || bus.bresp !== eb) begin
                mismatched++;
                $display("FAIL bp_b[%0d]: valids=%b bresp=%b required 11 bresp=%b",
                         c, {bus.bvalid, bus.rvalid}, bus.bresp, eb);
            end
            compared++;
            if (bus.rdata !== er.data || bus.rresp !== er.resp) begin
                mismatched++;
                $display("FAIL bp_r[%0d]: rdata=%h rresp=%b required rdata=%h rresp=%b",
                         c, bus.rdata, bus.rresp, er.data, er.resp);
            end
            compared++;
            if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
                mismatched++;
                $display("FAIL bp_ready[%0d]: got %b required 000", c, {bus.awready, bus.wready, bus.arready});
            end
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            mismatched++;
            $display("FAIL bp_release: got %b required 11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
    endtask

    task automatic test_read_during_write;
        int lat;
        logic [1:0] resp, eb;
        logic [DW-1:0] data;
        rexp_t er;
        exp_write(8'h10, 32'h1, 4'hF, 1'b1);
        drive_write(8'h10, 32'h1, 4'hF, 0, lat, resp);
        eb = bq.pop_front();
        compared++;
        if (resp !== eb) begin
            mismatched++;
            $display("FAIL rdw_pre: bresp=%b required %b", resp, eb);
        end
        exp_read(8'h10);
        exp_write(8'h10, 32'h2, 4'hF, 1'b1);
        @(posedge clk); #1;
        bus.awaddr = 8'h10; bus.wdata = 32'h2; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 8'h10; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        er = rq.pop_front();
        eb = bq.pop_front();
        compared++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11 || bus.bresp !== eb) begin
            mismatched++;
            $display("FAIL rdw_b: valids=%b bresp=%b required 11 bresp=%b", {bus.bvalid, bus.rvalid}, bus.bresp, eb);
        end
        compared++;
        if (bus.rdata !== er.data || bus.rresp !== er.resp) begin
            mismatched++;
            $display("FAIL rdw_old: rdata=%h rresp=%b required rdata=%h rresp=%b", bus.rdata, bus.rresp, er.data, er.resp);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        exp_read(8'h10);
        drive_read(8'h10, lat, data, resp);
        er = rq.pop_front();
        compared++;
        if (data !== er.data || resp !== er.resp) begin
            mismatched++;
            $display("FAIL rdw_new: rdata=%h rresp=%b required rdata=%h rresp=%b", data, resp, er.data, er.resp);
        end
    endtask

    task automatic test_reset_midflight;
        int lat;
        logic [1:0] resp, eb;
        logic [DW-1:0] data;
        rexp_t er;
        // committed write whose response is then dropped by reset
        exp_write(8'h24, 32'h5A5A1234, 4'hF, 1'b0);
        @(posedge clk); #1;
        bus.awaddr = 8'h24; bus.wdata = 32'h5A5A1234; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.bvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_bvalid: got %b required 1", bus.bvalid);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({bus.bvalid, bus.awready, bus.wready, bus.arready} !== 4'b0) begin
            mismatched++;
            $display("FAIL mid_async: got %b required 0000", {bus.bvalid, bus.awready, bus.wready, bus.arready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid} !== 4'b1110) begin
            mismatched++;
            $display("FAIL mid_release: got %b required 1110", {bus.awready, bus.wready, bus.arready, bus.bvalid});
        end
        // lone AW captured, then lost to a short reset pulse between edges
        @(posedge clk); #1;
        bus.awaddr = 8'h28; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            mismatched++;
            $display("FAIL aw_dropped: got %b required 11", {bus.awready, bus.wready});
        end
        exp_write(8'h2C, 32'h77777777, 4'hF, 1'b1);
        drive_write(8'h2C, 32'h77777777, 4'hF, 2, lat, resp);
        eb = bq.pop_front();
        compared++;
        if (lat !== 0 || resp !== eb) begin
            mismatched++;
            $display("FAIL post_rst_wr: lat=%0d bresp=%b required lat=0 bresp=%b", lat, resp, eb);
        end
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ra [4] = '{8'h24, 8'h28, 8'h2C, 8'h04};
            exp_read(ra[i]);
            drive_read(ra[i], lat, data, resp);
            er = rq.pop_front();
            compared++;
            if (lat !== 0 || data !== er.data || resp !== er.resp) begin
                mismatched++;
                $display("FAIL post_rst_rd[%0d]: lat=%0d rdata=%h rresp=%b required lat=0 rdata=%h rresp=%b",
                         i, lat, data, resp, er.data, er.resp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_readback();
        test_write_variants();
        test_backpressure();
        test_read_during_write();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 8, byte-address width.
REQ-003 Parameter DEPTH, default 32, number of implemented words; SHALL satisfy DEPTH*DATA_WIDTH/8 <= 2^ADDR_WIDTH.
REQ-004 s0_axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 s0_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 s0_axi_awaddr  in  ADDR_WIDTH  write byte address.
REQ-007 s0_axi_awvalid / s0_axi_awready  in / out  1 / 1  write-address handshake.
REQ-008 s0_axi_wdata  in  DATA_WIDTH  write data.
REQ-009 s0_axi_wstrb  in  DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i].
REQ-010 s0_axi_wvalid / s0_axi_wready  in / out  1 / 1  write-data handshake.
REQ-011 s0_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 s0_axi_bvalid / s0_axi_bready  out / in  1 / 1  write-response handshake.
REQ-013 s0_axi_araddr  in  ADDR_WIDTH  read byte address.
REQ-014 s0_axi_arvalid / s0_axi_arready  in / out  1 / 1  read-address handshake.
REQ-015 s0_axi_rdata  out  DATA_WIDTH  read data.
REQ-016 s0_axi_rresp  out  2  read response, encoding as REQ-011.
REQ-017 s0_axi_rvalid / s0_axi_rready  out / in  1 / 1  read-data handshake.

Function
REQ-018 Block SHALL be the AXI-Lite slave terminating the bus master port: a DEPTH-word memory with independent write and read paths.
REQ-019 Word index SHALL be addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits ignored (no unaligned error).
REQ-020 Address with word index >= DEPTH SHALL be out-of-range: write discarded with bresp=SLVERR; read returns rdata=0, rresp=SLVERR.
REQ-021 Write FSM states: W_IDLE, W_RESP.
REQ-022 W_IDLE: awready=1 until AW captured, wready=1 until W captured; AW and W accepted in either order or same cycle, each latched independently.
REQ-023 On the edge where both AW and W are held (captured this or an earlier edge), memory write SHALL commit with wstrb byte masking and FSM SHALL enter W_RESP with bvalid=1 next cycle.
REQ-024 wstrb=0 in range SHALL leave memory unchanged and return OKAY.
REQ-025 W_RESP: awready=wready=0; bvalid and bresp held stable until bvalid&bready, then W_IDLE with both captures cleared; bready=1 in W_RESP costs no extra cycle.
REQ-026 Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
REQ-027 AR handshake in R_IDLE SHALL register rdata/rresp from memory at that edge; rvalid=1 next cycle (1-cycle latency).
REQ-028 rdata, rresp SHALL be stable while rvalid=1 and rready=0; rvalid&rready returns to R_IDLE.
REQ-029 Simultaneous read and write commit to the same word on one edge: read SHALL return the pre-write value.
REQ-030 Write and read paths SHALL proceed concurrently without mutual stalls; max one outstanding transaction per path.
REQ-031 valid inputs deasserted before handshake SHALL leave state unchanged.

Reset
REQ-032 While s0_axi_aresetn=0: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; both FSMs idle; AW/W captures cleared.
REQ-033 Memory contents SHALL NOT be reset; reset mid-transaction SHALL drop the in-flight transaction (uncommitted write lost, pending response discarded).
REQ-034 First rising edge after deassertion: awready, wready, arready = 1.

Verification
REQ-035 Write 0xDEADBEEF @0x04 strb 0xF, AW and W same cycle -> bvalid next cycle, bresp=00; read 0x04 -> rdata=0xDEADBEEF, rresp=00 one cycle after AR.
REQ-036 W 3 cycles before AW to 0x08, data 0x11223344 strb 0x5 over 0xAAAAAAAA -> bresp=00; read 0x08 -> 0xAA22AA44.
REQ-037 Write @0x80 (index 32, DEPTH=32) -> bresp=10, no memory change; read 0x80 -> rdata=0, rresp=10.
REQ-038 Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp/rresp, rdata stable; awready/wready/arready=0 throughout.
REQ-039 Word 0x10 holds 0x1; write 0x2 commits same edge as AR 0x10 -> rdata=0x1; next read -> 0x2.
REQ-040 Assert reset while bvalid=1 -> bvalid=0 immediately; after release all readies=1, previously committed memory values readable unchanged.
